mac_frame_accum: RTL

Downstream consumer of the 8-bit multiply-add pipeline (`DATA_OUT = A*B + C`). It sums fixed-length frames of `N_SAMPLES` consecutive valid pipeline results, for example a dot product built from successive products. It also tracks the per-frame maximum. Each finished frame is presented on a valid/ready output register. The MAC pipeline cannot stall, so this block never back-pressures it. Results that cannot be stored are flagged as overrun.

---
 rtl/mac_frame_accum.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/mac_frame_accum.sv
// mac_frame_accum
//   Sums fixed-length frames of N_SAMPLES valid MAC results and tracks the
//   per-frame maximum. Each finished frame is presented on a valid/ready
//   output register. Input is never back-pressured; a frame that completes
//   while an unread frame is still held is dropped and flagged as overrun.
//
// Ports
//   clock      : single clock, rising edge
//   reset      : synchronous, active-high
//   in_data    : unsigned MAC result
//   in_valid   : in_data qualifies this cycle
//   clear      : flush the partial frame (output register untouched)
//   sum_out    : frame sum, held while sum_valid
//   max_out    : frame maximum, held while sum_valid
//   sum_valid  : output register holds an unread frame
//   sum_ready  : consumer accepts on sum_valid && sum_ready
//   busy       : partial frame in progress
//   overrun    : sticky, a completed frame was lost (cleared by reset only)
//   sat        : sum_out was saturated for the presented frame
module mac_frame_accum #(
    parameter int DATA_W    = 16,
    parameter int N_SAMPLES = 4,
    parameter int ACC_W     = 18,
    parameter int CNT_W     = 3
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    input  logic              clear,
    output logic [ACC_W-1:0]  sum_out,
    output logic [DATA_W-1:0] max_out,
    output logic              sum_valid,
    input  logic              sum_ready,
    output logic              busy,
    output logic              overrun,
    output logic              sat
);

    localparam int               SUM_W = ACC_W + 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(N_SAMPLES - 1);

    typedef enum logic {IDLE, ACC} stateType;

    stateType          state, stateNext;
    logic [CNT_W-1:0]  count, countNext;
    logic [ACC_W-1:0]  acc, accNext;
    logic [DATA_W-1:0] maxVal, maxNext;
    logic              accSat, accSatNext;
    logic              frameDone;

    // Saturating add and running maximum, shared by the accumulate step and
    // the final (completing) sample.
    logic [SUM_W-1:0]  sumExt;
    logic              addOvf;
    logic [ACC_W-1:0]  sumAdd;
    logic [DATA_W-1:0] largerMax;

    assign sumExt    = {1'b0, acc} + SUM_W'(in_data);
    assign addOvf    = sumExt[ACC_W];
    assign sumAdd    = addOvf ? '1 : sumExt[ACC_W-1:0];
    assign largerMax = (in_data > maxVal) ? in_data : maxVal;

    always_comb begin
        stateNext  = state;
        countNext  = count;
        accNext    = acc;
        maxNext    = maxVal;
        accSatNext = accSat;
        frameDone  = 1'b0;
        if (clear) begin
            // clear wins over a coincident valid sample, which is dropped
            stateNext  = IDLE;
            countNext  = '0;
            accNext    = '0;
            maxNext    = '0;
            accSatNext = 1'b0;
        end else if (in_valid) begin
            case (state)
                IDLE: begin
                    stateNext  = ACC;
                    accNext    = ACC_W'(in_data);
                    maxNext    = in_data;
                    countNext  = CNT_W'(1);
                    accSatNext = 1'b0;
                end
                ACC: begin
                    if (count == LAST) begin
                        frameDone  = 1'b1;
                        stateNext  = IDLE;
                        countNext  = '0;
                        accNext    = '0;
                        maxNext    = '0;
                        accSatNext = 1'b0;
                    end else begin
                        accNext    = sumAdd;
                        maxNext    = largerMax;
                        accSatNext = accSat | addOvf;
                        countNext  = count + CNT_W'(1);
                    end
                end
                default: stateNext = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            count     <= '0;
            acc       <= '0;
            maxVal    <= '0;
            accSat    <= 1'b0;
            sum_out   <= '0;
            max_out   <= '0;
            sum_valid <= 1'b0;
            busy      <= 1'b0;
            overrun   <= 1'b0;
            sat       <= 1'b0;
        end else begin
            state  <= stateNext;
            count  <= countNext;
            acc    <= accNext;
            maxVal <= maxNext;
            accSat <= accSatNext;
            busy   <= (stateNext == ACC);
            if (frameDone) begin
                // A coincident accept frees the register for the new frame.
                if (!sum_valid || sum_ready) begin
                    sum_out   <= sumAdd;
                    max_out   <= largerMax;
                    sat       <= accSat | addOvf;
                    sum_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (sum_valid && sum_ready) begin
                sum_valid <= 1'b0;
            end
        end
    end

endmodule
